vx_ahb_burst_adapter: RTL and testbench
=======================================

VX_AHB_BURST_ADAPTER -- requirements
Module: VX_ahb_burst_adapter

Interface
REQ-001 SHALL have parameter VX_DATA_WIDTH, default 512, Vortex line width in bits.
REQ-002 SHALL have parameter VX_ADDR_WIDTH, default 26, line address width.
REQ-003 SHALL have parameter VX_TAG_WIDTH, default 8, request tag width.
REQ-004 SHALL have parameter AHB_DATA_WIDTH, default 32, AHB bus width in bits (32 or 64).
REQ-005 SHALL have localparam BEATS = VX_DATA_WIDTH/AHB_DATA_WIDTH (power of two, 2..16) and LINE_BYTES = VX_DATA_WIDTH/8 (at most 1024).
REQ-006 SHALL have ports: clk in 1, clock; reset in 1, asynchronous active-high reset.
REQ-007 SHALL have ports: mem_req_valid in 1; mem_req_rw in 1 (1 = write); mem_req_byteen in LINE_BYTES; mem_req_addr in VX_ADDR_WIDTH; mem_req_data in VX_DATA_WIDTH; mem_req_tag in VX_TAG_WIDTH; mem_req_ready out 1.
REQ-008 SHALL have ports: mem_rsp_valid out 1; mem_rsp_data out VX_DATA_WIDTH; mem_rsp_tag out VX_TAG_WIDTH; mem_rsp_err out 1; mem_rsp_ready in 1.
REQ-009 SHALL have ports: HSEL out 1; HADDR out 32; HTRANS out 2; HBURST out 3; HSIZE out 3; HWRITE out 1; HWDATA out AHB_DATA_WIDTH; HWSTRB out AHB_DATA_WIDTH/8; HRDATA in AHB_DATA_WIDTH; HREADY in 1; HRESP in 1.

Function
REQ-010 SHALL implement states IDLE, BURST, DRAIN, RESP, ERR.
REQ-011 IDLE: mem_req_ready=1; on mem_req_valid, SHALL capture rw, byteen, data and tag, set base = {addr, log2(LINE_BYTES) zeros}, clear the address-beat and data-beat counters, and go to BURST.
REQ-012 mem_req_ready SHALL be 0 in every state other than IDLE.
REQ-013 BURST: SHALL drive HSEL=1, HBURST=3'b001 (INCR), HSIZE=log2(AHB_DATA_WIDTH/8), HWRITE=rw, HADDR = base + abeat*AHB_DATA_WIDTH/8.
REQ-014 HTRANS SHALL be NONSEQ (2'b10) for abeat=0 and SEQ (2'b11) for later beats; abeat SHALL advance only when HREADY=1.
REQ-015 Address and data phases SHALL be pipelined: the data phase of beat k SHALL coincide with the address phase of beat k+1.
REQ-016 During a data phase, HWDATA and HWSTRB SHALL be the dbeat slice of the captured data and byteen; on a read, HRDATA SHALL be stored into slice dbeat when HREADY=1.
REQ-017 dbeat SHALL advance on HREADY=1 in any cycle where a data phase is outstanding.
REQ-018 After the last address phase is accepted, the FSM SHALL enter DRAIN with HTRANS=IDLE (2'b00) and HSEL=0; DRAIN SHALL exit when the last data phase completes with HREADY=1.
REQ-019 On DRAIN exit, a read SHALL go to RESP; an error-free write SHALL go to IDLE and produce no response.
REQ-020 RESP: mem_rsp_valid=1 with mem_rsp_data, mem_rsp_tag and mem_rsp_err stable until mem_rsp_ready=1; the FSM SHALL then go to IDLE.
REQ-021 Error: HRESP=1 with HREADY=0 (first error cycle) SHALL force HTRANS=IDLE in that cycle and move the FSM to ERR; remaining beats SHALL be abandoned.
REQ-022 ERR: SHALL wait for HREADY=1 (second error cycle), set the error flag, and go to RESP for both reads and writes with mem_rsp_err=1.
REQ-023 Uncorrupted reads SHALL return mem_rsp_err=0.
REQ-024 Zero-wait-state latency: request accepted in cycle T, first NONSEQ in T+1, last data phase in T+1+BEATS, read response in T+2+BEATS.
REQ-025 Wait states SHALL hold HADDR, HTRANS, HWDATA and HWSTRB stable.

Reset
REQ-026 While reset=1, the FSM SHALL be in IDLE, counters and buffers SHALL be 0, and all outputs SHALL be 0 (HTRANS=IDLE) except mem_req_ready=1.
REQ-027 Reset asserted mid-burst SHALL abort immediately, with no response issued.

Structure
REQ-028 State enum and the HTRANS/HBURST/HSIZE encodings SHALL be placed in the shared package ahb_pkg.
REQ-029 The beat counters SHALL use the existing counter sub-module, parametrised to width log2(BEATS).

Verification
REQ-030 Read, AHB_DATA_WIDTH=32, addr=0x10, no waits -> HADDR 0x400..0x43C (16 beats, NONSEQ then SEQ), and mem_rsp_valid asserted in T+18 with the words concatenated in order.
REQ-031 Write, byteen=all ones except byte 0, data word k=k -> HWDATA beat k=k, HWSTRB beat0=4'b1110 and others 4'hF, and no mem_rsp.
REQ-032 Read with 2 wait states on beat 5 -> beats 5/6 held stable for 3 cycles, and the response arrives 2 cycles later than in REQ-030.
REQ-033 HRESP error on beat 3 of a write -> HTRANS=IDLE in the first error cycle, no further beats issued, and mem_rsp_valid=1 with mem_rsp_err=1.
REQ-034 mem_rsp_ready held 0 for 4 cycles -> response held stable and mem_req_ready=0 throughout; then reset mid-burst -> all outputs idle next edge.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the burst adapter state type.
package ahb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BURST,
      ST_DRAIN,
      ST_RESP,
      ST_ERR
   } adapter_state_e;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011
   } hburst_e;

   // HSIZE encodes the transfer size as log2 of the byte count.
   function automatic logic [2:0] hsize_for_width(input int unsigned bus_bits);
      return 3'($clog2(bus_bits / 8));
   endfunction

endpackage

// File: rtl/vx_ahb_burst_adapter_counter.sv
// Beat counter: synchronous clear, increment on enable, wraps naturally.
module vx_ahb_burst_adapter_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   // Clear has priority over increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/vx_ahb_burst_adapter.sv
// Converts one Vortex line request into a pipelined AHB-Lite INCR burst.
module vx_ahb_burst_adapter
   import ahb_pkg::*;
#(
   parameter int unsigned VX_DATA_WIDTH  = 512,
   parameter int unsigned VX_ADDR_WIDTH  = 26,
   parameter int unsigned VX_TAG_WIDTH   = 8,
   parameter int unsigned AHB_DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          mem_req_valid,
   input  logic                          mem_req_rw,
   input  logic [VX_DATA_WIDTH/8-1:0]    mem_req_byteen,
   input  logic [VX_ADDR_WIDTH-1:0]      mem_req_addr,
   input  logic [VX_DATA_WIDTH-1:0]      mem_req_data,
   input  logic [VX_TAG_WIDTH-1:0]       mem_req_tag,
   output logic                          mem_req_ready,
   output logic                          mem_rsp_valid,
   output logic [VX_DATA_WIDTH-1:0]      mem_rsp_data,
   output logic [VX_TAG_WIDTH-1:0]       mem_rsp_tag,
   output logic                          mem_rsp_err,
   input  logic                          mem_rsp_ready,
   output logic                          HSEL,
   output logic [31:0]                   HADDR,
   output logic [1:0]                    HTRANS,
   output logic [2:0]                    HBURST,
   output logic [2:0]                    HSIZE,
   output logic                          HWRITE,
   output logic [AHB_DATA_WIDTH-1:0]     HWDATA,
   output logic [AHB_DATA_WIDTH/8-1:0]   HWSTRB,
   input  logic [AHB_DATA_WIDTH-1:0]     HRDATA,
   input  logic                          HREADY,
   input  logic                          HRESP
);

   localparam int unsigned BEATS      = VX_DATA_WIDTH / AHB_DATA_WIDTH;
   localparam int unsigned LINE_BYTES = VX_DATA_WIDTH / 8;
   localparam int unsigned STRB_W     = AHB_DATA_WIDTH / 8;
   localparam int unsigned CNT_W      = $clog2(BEATS);
   localparam int unsigned LINE_SHIFT = $clog2(LINE_BYTES);
   localparam int unsigned BEAT_SHIFT = $clog2(STRB_W);
   localparam logic [2:0]  HSIZE_VAL  = hsize_for_width(AHB_DATA_WIDTH);

   adapter_state_e           state;
   logic                     rw_q;
   logic [LINE_BYTES-1:0]    byteen_q;
   logic [VX_DATA_WIDTH-1:0] wdata_q;
   logic [VX_DATA_WIDTH-1:0] rdata_q;
   logic [VX_TAG_WIDTH-1:0]  tag_q;
   logic [31:0]              base_q;
   logic                     dpend_q;
   logic                     err_q;
   logic [CNT_W-1:0]         abeat;
   logic [CNT_W-1:0]         dbeat;

   logic in_bus;
   logic accept;
   logic addr_done;
   logic data_done;
   logic err_first;

   assign in_bus    = (state == ST_BURST) || (state == ST_DRAIN);
   assign accept    = (state == ST_IDLE) && mem_req_valid;
   // First cycle of the two-cycle ERROR response: slave stalls with HRESP high.
   assign err_first = in_bus && dpend_q && HRESP && !HREADY;
   assign addr_done = (state == ST_BURST) && HREADY;
   assign data_done = in_bus && dpend_q && HREADY;

   vx_ahb_burst_adapter_counter #(
      .WIDTH (CNT_W)
   ) u_abeat_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (accept),
      .en    (addr_done),
      .count (abeat)
   );

   vx_ahb_burst_adapter_counter #(
      .WIDTH (CNT_W)
   ) u_dbeat_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (accept),
      .en    (data_done),
      .count (dbeat)
   );

   // Transaction FSM plus request capture and read-data assembly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         rw_q     <= 1'b0;
         byteen_q <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         tag_q    <= '0;
         base_q   <= '0;
         dpend_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mem_req_valid) begin
                  rw_q     <= mem_req_rw;
                  byteen_q <= mem_req_byteen;
                  wdata_q  <= mem_req_data;
                  tag_q    <= mem_req_tag;
                  base_q   <= 32'(mem_req_addr) << LINE_SHIFT;
                  rdata_q  <= '0;
                  dpend_q  <= 1'b0;
                  err_q    <= 1'b0;
                  state    <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (err_first) begin
                  dpend_q <= 1'b0;
                  state   <= ST_ERR;
               end else if (HREADY) begin
                  // Every accepted address leaves exactly one data phase behind it.
                  dpend_q <= 1'b1;
                  if (abeat == CNT_W'(BEATS - 1)) begin
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (err_first) begin
                  dpend_q <= 1'b0;
                  state   <= ST_ERR;
               end else if (HREADY) begin
                  dpend_q <= 1'b0;
                  state   <= rw_q ? ST_IDLE : ST_RESP;
               end
            end
            ST_ERR: begin
               if (HREADY) begin
                  err_q <= 1'b1;
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (mem_rsp_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (data_done && !rw_q) begin
            rdata_q[dbeat * AHB_DATA_WIDTH +: AHB_DATA_WIDTH] <= HRDATA;
         end
      end
   end

   // Bus outputs decoded from registered state; HTRANS is squashed in the first error cycle.
   always_comb begin
      HSEL   = 1'b0;
      HTRANS = HTRANS_IDLE;
      HBURST = '0;
      HSIZE  = '0;
      HWRITE = 1'b0;
      HADDR  = '0;
      HWDATA = '0;
      HWSTRB = '0;
      if (state == ST_BURST) begin
         HSEL   = 1'b1;
         HBURST = HBURST_INCR;
         HSIZE  = HSIZE_VAL;
         HWRITE = rw_q;
         HADDR  = base_q + (32'(abeat) << BEAT_SHIFT);
         if (!err_first) begin
            HTRANS = (abeat == '0) ? HTRANS_NONSEQ : HTRANS_SEQ;
         end
      end
      if (dpend_q && rw_q) begin
         HWDATA = wdata_q[dbeat * AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
         HWSTRB = byteen_q[dbeat * STRB_W +: STRB_W];
      end
   end

   assign mem_req_ready = (state == ST_IDLE);
   assign mem_rsp_valid = (state == ST_RESP);
   assign mem_rsp_data  = rdata_q;
   assign mem_rsp_tag   = tag_q;
   assign mem_rsp_err   = err_q;

endmodule

// File: tb/tb_vx_ahb_burst_adapter.sv
// Self-checking bench for vx_ahb_burst_adapter with a cycle-level expectation model.
module tb_vx_ahb_burst_adapter;

   localparam int BEATS = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic         mem_req_valid;
   logic         mem_req_rw;
   logic [63:0]  mem_req_byteen;
   logic [25:0]  mem_req_addr;
   logic [511:0] mem_req_data;
   logic [7:0]   mem_req_tag;
   logic         mem_req_ready;
   logic         mem_rsp_valid;
   logic [511:0] mem_rsp_data;
   logic [7:0]   mem_rsp_tag;
   logic         mem_rsp_err;
   logic         mem_rsp_ready;
   logic         HSEL;
   logic [31:0]  HADDR;
   logic [1:0]   HTRANS;
   logic [2:0]   HBURST;
   logic [2:0]   HSIZE;
   logic         HWRITE;
   logic [31:0]  HWDATA;
   logic [3:0]   HWSTRB;
   logic [31:0]  HRDATA;
   logic         HREADY;
   logic         HRESP;

   vx_ahb_burst_adapter #(
      .VX_DATA_WIDTH  (512),
      .VX_ADDR_WIDTH  (26),
      .VX_TAG_WIDTH   (8),
      .AHB_DATA_WIDTH (32)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_req_valid  (mem_req_valid),
      .mem_req_rw     (mem_req_rw),
      .mem_req_byteen (mem_req_byteen),
      .mem_req_addr   (mem_req_addr),
      .mem_req_data   (mem_req_data),
      .mem_req_tag    (mem_req_tag),
      .mem_req_ready  (mem_req_ready),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .mem_rsp_tag    (mem_rsp_tag),
      .mem_rsp_err    (mem_rsp_err),
      .mem_rsp_ready  (mem_rsp_ready),
      .HSEL           (HSEL),
      .HADDR          (HADDR),
      .HTRANS         (HTRANS),
      .HBURST         (HBURST),
      .HSIZE          (HSIZE),
      .HWRITE         (HWRITE),
      .HWDATA         (HWDATA),
      .HWSTRB         (HWSTRB),
      .HRDATA         (HRDATA),
      .HREADY         (HREADY),
      .HRESP          (HRESP)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Current transaction as seen by the model.
   bit           t_rw;
   logic [25:0]  t_addr;
   logic [31:0]  t_base;
   logic [7:0]   t_tag;
   logic [511:0] t_data;
   logic [63:0]  t_byteen;
   bit           t_wait [64];
   int           t_err;
   int           t_hold;

   // Expected outputs for the current cycle.
   bit           chk_en = 1'b0;
   bit           chk_rsp;
   bit           chk_rdata;
   logic         exp_hsel;
   logic [1:0]   exp_htrans;
   logic [31:0]  exp_haddr;
   logic [2:0]   exp_hburst;
   logic [2:0]   exp_hsize;
   logic         exp_hwrite;
   logic [31:0]  exp_hwdata;
   logic [3:0]   exp_hwstrb;
   logic         exp_req_ready;
   logic         exp_rsp_valid;
   logic [511:0] exp_rsp_data;
   logic [7:0]   exp_rsp_tag;
   logic         exp_rsp_err;

   // Per-cycle captures used for the literal pins.
   logic [31:0]  cap_haddr  [64];
   logic [1:0]   cap_htrans [64];
   logic [31:0]  cap_hwdata [64];
   logic [3:0]   cap_hwstrb [64];
   logic [511:0] cap_rsp_data;
   logic         cap_rsp_err;
   int           rsp_rel;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rword(input int k);
      return 32'hA05A0000 + (32'(k) << 24) + 32'(k);
   endfunction

   function automatic logic [511:0] read_line();
      logic [511:0] l;
      for (int k = 0; k < BEATS; k++) l[32*k +: 32] = rword(k);
      return l;
   endfunction

   // HREADY the slave gives in relative cycle c.
   function automatic bit rdy(input int c);
      if (t_err >= 0 && c == t_err) return 1'b0;
      if (t_err >= 0 && c == t_err + 1) return 1'b1;
      return !t_wait[c];
   endfunction

   // Number of completed (HREADY high) bus cycles before c: address k is on the
   // bus while k are complete, and data of beat k-1 is in flight alongside it.
   function automatic int cnt_before(input int c);
      int n = 0;
      for (int j = 0; j < c; j++) begin
         if (rdy(j) && (t_err < 0 || j < t_err)) n++;
      end
      return n;
   endfunction

   task automatic set_idle_exp(input bit in_reset);
      exp_hsel      = 1'b0;
      exp_htrans    = 2'b00;
      exp_haddr     = '0;
      exp_hburst    = '0;
      exp_hsize     = '0;
      exp_hwrite    = 1'b0;
      exp_hwdata    = '0;
      exp_hwstrb    = '0;
      exp_req_ready = 1'b1;
      exp_rsp_valid = 1'b0;
      exp_rsp_data  = '0;
      exp_rsp_tag   = '0;
      exp_rsp_err   = 1'b0;
      chk_rsp       = in_reset;
      chk_rdata     = in_reset;
   endtask

   task automatic model_cycle(input int c, input int done);
      int n;
      int d;
      n = cnt_before(c);
      d = n - 1;
      set_idle_exp(1'b0);
      exp_req_ready = 1'b0;
      if (c >= done) begin
         if ((t_rw && t_err < 0) || c > done + t_hold) begin
            exp_req_ready = 1'b1;
         end else begin
            exp_rsp_valid = 1'b1;
            exp_rsp_tag   = t_tag;
            exp_rsp_err   = (t_err >= 0);
            exp_rsp_data  = read_line();
            chk_rsp       = 1'b1;
            chk_rdata     = !t_rw;
         end
      end else if (t_err < 0 || c <= t_err) begin
         if (n < BEATS) begin
            exp_hsel   = 1'b1;
            exp_hburst = 3'b001;
            exp_hsize  = 3'd2;
            exp_hwrite = t_rw;
            exp_haddr  = t_base + 32'(n * 4);
            if (t_err >= 0 && c == t_err) exp_htrans = 2'b00;
            else exp_htrans = (n == 0) ? 2'b10 : 2'b11;
         end
         if (t_rw && d >= 0 && d < BEATS) begin
            exp_hwdata = t_data[32*d +: 32];
            exp_hwstrb = t_byteen[4*d +: 4];
         end
      end
   endtask

   // Single compare point: all DUT outputs against the model, every cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         check("HSEL",          512'(HSEL),          512'(exp_hsel));
         check("HTRANS",        512'(HTRANS),        512'(exp_htrans));
         check("HADDR",         512'(HADDR),         512'(exp_haddr));
         check("HBURST",        512'(HBURST),        512'(exp_hburst));
         check("HSIZE",         512'(HSIZE),         512'(exp_hsize));
         check("HWRITE",        512'(HWRITE),        512'(exp_hwrite));
         check("HWDATA",        512'(HWDATA),        512'(exp_hwdata));
         check("HWSTRB",        512'(HWSTRB),        512'(exp_hwstrb));
         check("mem_req_ready", 512'(mem_req_ready), 512'(exp_req_ready));
         check("mem_rsp_valid", 512'(mem_rsp_valid), 512'(exp_rsp_valid));
         if (chk_rsp) begin
            check("mem_rsp_tag", 512'(mem_rsp_tag), 512'(exp_rsp_tag));
            check("mem_rsp_err", 512'(mem_rsp_err), 512'(exp_rsp_err));
            if (chk_rdata) check("mem_rsp_data", mem_rsp_data, exp_rsp_data);
         end
      end
   end

   task automatic clear_txn();
      foreach (t_wait[i]) t_wait[i] = 1'b0;
      t_err  = -1;
      t_hold = 0;
   endtask

   // Runs one request from acceptance to idle (or to a mid-burst reset).
   task automatic run_txn(input int hold, input int abort_at, input int exp_rsp_rel,
                          input logic [31:0] exp_haddr0);
      int done;
      int last;
      int n;
      t_hold  = hold;
      t_base  = 32'(t_addr) << 6;
      rsp_rel = -1;
      cap_rsp_data = '0;
      cap_rsp_err  = 1'b0;
      done = 64;
      if (t_err >= 0) done = t_err + 2;
      else begin
         for (int c = 0; c < 64; c++) begin
            if (cnt_before(c) == BEATS + 1) begin
               done = c;
               break;
            end
         end
      end
      last = (t_rw && t_err < 0) ? done : done + t_hold + 1;

      mem_req_valid  = 1'b1;
      mem_req_rw     = t_rw;
      mem_req_addr   = t_addr;
      mem_req_tag    = t_tag;
      mem_req_data   = t_data;
      mem_req_byteen = t_byteen;
      HREADY         = 1'b1;
      HRESP          = 1'b0;
      mem_rsp_ready  = 1'b0;
      set_idle_exp(1'b0);
      @(posedge clk); #1;
      mem_req_valid = 1'b0;
      mem_req_data  = '1;

      for (int c = 0; c <= last; c++) begin
         if (c == abort_at) begin
            reset = 1'b1;
            HREADY = 1'b1;
            HRESP  = 1'b0;
            set_idle_exp(1'b1);
            @(negedge clk);
            check("abort_htrans_idle", 512'(HTRANS), 512'(2'b00));
            @(posedge clk); #1;
            @(negedge clk);
            @(posedge clk); #1;
            reset = 1'b0;
            set_idle_exp(1'b0);
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               if (mem_rsp_valid && rsp_rel < 0) rsp_rel = c + k + 1;
               @(posedge clk); #1;
            end
            break;
         end
         n = cnt_before(c);
         HREADY = rdy(c);
         HRESP  = (t_err >= 0 && (c == t_err || c == t_err + 1));
         HRDATA = (rdy(c) && n >= 1 && n <= BEATS) ? rword(n - 1) : 32'hDEADBEEF;
         mem_rsp_ready = (c == done + t_hold) && !(t_rw && t_err < 0);
         model_cycle(c, done);
         @(negedge clk);
         cap_haddr[c]  = HADDR;
         cap_htrans[c] = HTRANS;
         cap_hwdata[c] = HWDATA;
         cap_hwstrb[c] = HWSTRB;
         if (mem_rsp_valid && rsp_rel < 0) begin
            rsp_rel      = c + 1;
            cap_rsp_data = mem_rsp_data;
            cap_rsp_err  = mem_rsp_err;
         end
         @(posedge clk); #1;
      end
      HREADY = 1'b1;
      HRESP  = 1'b0;
      mem_rsp_ready = 1'b0;
      set_idle_exp(1'b0);
      check("first_haddr", 512'(cap_haddr[0]), 512'(exp_haddr0));
      check("rsp_cycle",   512'(rsp_rel),      512'(exp_rsp_rel));
   endtask

   initial begin
      reset          = 1'b1;
      mem_req_valid  = 1'b0;
      mem_req_rw     = 1'b0;
      mem_req_byteen = '0;
      mem_req_addr   = '0;
      mem_req_data   = '0;
      mem_req_tag    = '0;
      mem_rsp_ready  = 1'b0;
      HRDATA         = '0;
      HREADY         = 1'b1;
      HRESP          = 1'b0;
      clear_txn();
      set_idle_exp(1'b1);
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_req_ready", 512'(mem_req_ready), 512'(1'b1));
      @(posedge clk); #1;
      reset = 1'b0;
      set_idle_exp(1'b0);
      @(posedge clk); #1;

      // Zero-wait read of line 0x10.
      clear_txn();
      t_rw = 1'b0; t_addr = 26'h10; t_tag = 8'h3C; t_byteen = '1; t_data = '0;
      run_txn(0, -1, 18, 32'h400);
      check("rd_beat1_htrans",  512'(cap_htrans[1]), 512'(2'b11));
      check("rd_beat15_haddr",  512'(cap_haddr[15]), 512'(32'h43C));
      check("rd_word0",         512'(cap_rsp_data[31:0]),    512'(32'hA05A0000));
      check("rd_word15",        512'(cap_rsp_data[511:480]), 512'(32'hAF5A000F));

      // Write, byte 0 disabled, word k = k.
      clear_txn();
      t_rw = 1'b1; t_addr = 26'h2A5; t_tag = 8'h11; t_byteen = {{63{1'b1}}, 1'b0};
      for (int k = 0; k < BEATS; k++) t_data[32*k +: 32] = 32'(k);
      run_txn(0, -1, -1, 32'hA940);
      check("wr_beat0_strb",  512'(cap_hwstrb[1]),  512'(4'b1110));
      check("wr_beat1_strb",  512'(cap_hwstrb[2]),  512'(4'hF));
      check("wr_beat3_data",  512'(cap_hwdata[4]),  512'(32'd3));
      check("wr_beat15_data", 512'(cap_hwdata[16]), 512'(32'd15));

      // Read with two wait states in the data phase of beat 5.
      clear_txn();
      t_rw = 1'b0; t_addr = 26'h10; t_tag = 8'h5A; t_byteen = '1; t_data = '0;
      t_wait[6] = 1'b1; t_wait[7] = 1'b1;
      run_txn(0, -1, 20, 32'h400);
      for (int c = 6; c <= 8; c++) begin
         check("wait_haddr_hold",  512'(cap_haddr[c]),  512'(32'h418));
         check("wait_htrans_hold", 512'(cap_htrans[c]), 512'(2'b11));
      end

      // Write with an ERROR response on beat 3.
      clear_txn();
      t_rw = 1'b1; t_addr = 26'h3; t_tag = 8'h77; t_byteen = '1;
      for (int k = 0; k < BEATS; k++) t_data[32*k +: 32] = 32'(k);
      t_err = 4;
      run_txn(0, -1, 7, 32'hC0);
      check("err_htrans_idle", 512'(cap_htrans[4]), 512'(2'b00));
      check("err_no_more",     512'(cap_htrans[5]), 512'(2'b00));
      check("err_flag",        512'(cap_rsp_err),   512'(1'b1));

      // Read whose response is back-pressured for 4 cycles.
      clear_txn();
      t_rw = 1'b0; t_addr = 26'h155; t_tag = 8'hC3; t_byteen = '1; t_data = '0;
      run_txn(4, -1, 18, 32'h5540);

      // Reset in the middle of a read burst: no response afterwards.
      clear_txn();
      t_rw = 1'b0; t_addr = 26'h20; t_tag = 8'h99; t_byteen = '1; t_data = '0;
      run_txn(0, 5, -1, 32'h800);

      // Normal read after the aborted one.
      clear_txn();
      t_rw = 1'b0; t_addr = 26'h0; t_tag = 8'h01; t_byteen = '1; t_data = '0;
      run_txn(0, -1, 18, 32'h0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
